// File: rtl/i2fn_pipe.sv
// Three-stage integer-to-float converter with valid/ready flow control and a global stall.
// Define I2F_RMM_EN to enable round-to-nearest-ties-away (rm=4); otherwise rm=4 rounds as RNE.
module i2fn_pipe #(
  parameter int IWID  = 32,
  parameter int EXPW  = 8,
  parameter int FRACW = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic                  op,
  input  logic [2:0]            rm,
  input  logic [IWID-1:0]       i,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [EXPW+FRACW:0]   o,
  output logic                  o_inexact,
  output logic                  o_overflow
);
  localparam int BIAS = (1 << (EXPW-1)) - 1;
  localparam int EXW  = 12;
  localparam int LZW  = $clog2(IWID);
  localparam int XW   = IWID + FRACW + 2;

  logic adv;
  assign adv     = ce & (~o_valid | o_ready);
  assign i_ready = adv;

  // ---------------- stage 1: sign / magnitude ----------------
  logic            v1_reg, sign1_reg, zero1_reg;
  logic [2:0]      rm1_reg;
  logic [IWID-1:0] mag1_reg;
  logic            sign_in;
  logic [IWID-1:0] mag_in;

  assign sign_in = op & i[IWID-1];
  assign mag_in  = sign_in ? (~i + {{(IWID-1){1'b0}}, 1'b1}) : i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg    <= 1'b0;
      sign1_reg <= 1'b0;
      zero1_reg <= 1'b0;
      rm1_reg   <= '0;
      mag1_reg  <= '0;
    end else if (adv) begin
      v1_reg    <= i_valid;
      sign1_reg <= sign_in;
      zero1_reg <= (i == '0);
      rm1_reg   <= rm;
      mag1_reg  <= mag_in;
    end
  end

  // ---------------- stage 2: normalise ----------------
  logic [LZW-1:0]  lz;
  logic [IWID-1:0] norm_next;
  logic [EXW-1:0]  e_next;

  always_comb begin
    lz = '0;
    // Scanning upward lets the highest set bit win the count.
    for (int k = 0; k < IWID; k++) begin
      if (mag1_reg[k]) lz = LZW'(IWID - 1 - k);
    end
    norm_next = mag1_reg << lz;
    e_next    = EXW'(IWID - 1) - EXW'(lz);
  end

  logic            v2_reg, sign2_reg, zero2_reg;
  logic [2:0]      rm2_reg;
  logic [IWID-1:0] norm2_reg;
  logic [EXW-1:0]  e2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_reg    <= 1'b0;
      sign2_reg <= 1'b0;
      zero2_reg <= 1'b0;
      rm2_reg   <= '0;
      norm2_reg <= '0;
      e2_reg    <= '0;
    end else if (adv) begin
      v2_reg    <= v1_reg;
      sign2_reg <= sign1_reg;
      zero2_reg <= zero1_reg;
      rm2_reg   <= rm1_reg;
      norm2_reg <= norm_next;
      e2_reg    <= e_next;
    end
  end

  // ---------------- stage 3: round and pack ----------------
  logic [XW-1:0]          xv;
  logic [FRACW:0]         mant;
  logic                   gbit, rbit, sbit, inc, to_inf, ovf;
  logic [FRACW+1:0]       sum;
  logic [EXW-1:0]         ef;
  logic [EXPW+FRACW:0]    res_next;
  logic                   inx_next, ovf_next;

  always_comb begin
    // Zero padding below the integer makes narrow inputs round exactly.
    xv   = {norm2_reg, {(FRACW+2){1'b0}}};
    mant = xv[XW-1 -: FRACW+1];
    gbit = mant[0];
    rbit = xv[XW-FRACW-2];
    sbit = |xv[XW-FRACW-3:0];

    case (rm2_reg)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (rbit | sbit) & ~sign2_reg;
      3'd3:    inc = (rbit | sbit) & sign2_reg;
`ifdef I2F_RMM_EN
      3'd4:    inc = rbit;
`endif
      default: inc = rbit & (gbit | sbit);
    endcase

    case (rm2_reg)
      3'd1:    to_inf = 1'b0;
      3'd2:    to_inf = ~sign2_reg;
      3'd3:    to_inf = sign2_reg;
      default: to_inf = 1'b1;
    endcase

    sum = {1'b0, mant} + {{(FRACW+1){1'b0}}, inc};
    // Top two sum bits are 01 normally and 10 after a rounding carry: adds 0 or 1 to e.
    ef  = e2_reg + EXW'(sum[FRACW+1:FRACW]) - EXW'(1);
    ovf = (ef > EXW'(BIAS));

    res_next = {sign2_reg, EXPW'(ef + EXW'(BIAS)), sum[FRACW-1:0]};
    inx_next = rbit | sbit;
    ovf_next = 1'b0;
    if (zero2_reg) begin
      res_next = '0;
      inx_next = 1'b0;
    end else if (ovf) begin
      ovf_next = 1'b1;
      inx_next = 1'b1;
      res_next = to_inf ? {sign2_reg, {EXPW{1'b1}}, {FRACW{1'b0}}}
                        : {sign2_reg, {(EXPW-1){1'b1}}, 1'b0, {FRACW{1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o          <= '0;
      o_inexact  <= 1'b0;
      o_overflow <= 1'b0;
    end else if (adv) begin
      o_valid    <= v2_reg;
      o          <= res_next;
      o_inexact  <= inx_next;
      o_overflow <= ovf_next;
    end
  end

endmodule

// File: tb/tb_i2fn_pipe.sv
// Scoreboard bench for i2fn_pipe: float32 and float16 instances share one stimulus stream.
module tb_i2fn_pipe;
  logic        clk = 1'b0, rst = 1'b1, ce = 1'b1, i_valid = 1'b0, op = 1'b0, o_ready = 1'b1;
  logic [2:0]  rm = 3'd0;
  logic [31:0] i = '0;
  logic        i_ready, o_valid, o_inexact, o_overflow;
  logic [31:0] o;
  logic        i_ready_h, o_valid_h, inx_h, ovf_h;
  logic [15:0] oh;

  i2fn_pipe dut (
    .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_ready(i_ready), .op(op), .rm(rm),
    .i(i), .o_valid(o_valid), .o_ready(o_ready), .o(o), .o_inexact(o_inexact),
    .o_overflow(o_overflow));

  i2fn_pipe #(.IWID(32), .EXPW(5), .FRACW(10)) dut_h (
    .clk(clk), .rst(rst), .ce(ce), .i_valid(i_valid), .i_ready(i_ready_h), .op(op), .rm(rm),
    .i(i), .o_valid(o_valid_h), .o_ready(o_ready), .o(oh), .o_inexact(inx_h),
    .o_overflow(ovf_h));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: shift-and-remainder rounding on a 64-bit magnitude; returns {ovf, inexact, bits}.
  function automatic logic [33:0] model(input logic [31:0] x, input logic s_op,
                                        input logic [2:0] m, input int ew, input int fw);
    logic sgn, inc, ovf, to_inf;
    longint unsigned mag, q, rem, half, ex, fr, res;
    int p, sh, bias, mode;
    sgn = s_op & x[31];
    mag = sgn ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
    if (mag == 0) return '0;
    p = 0;
    for (int k = 0; k < 33; k++) if (mag[k]) p = k;
    case (m)
      3'd1: mode = 1;
      3'd2: mode = 2;
      3'd3: mode = 3;
`ifdef I2F_RMM_EN
      3'd4: mode = 4;
`endif
      default: mode = 0;
    endcase
    if (p <= fw) begin
      sh = 0; q = mag << (fw - p); rem = 0; half = 1;
    end else begin
      sh = p - fw; q = mag >> sh; rem = mag & ((64'd1 << sh) - 1); half = 64'd1 << (sh - 1);
    end
    case (mode)
      1: inc = 1'b0;
      2: inc = (rem != 0) && !sgn;
      3: inc = (rem != 0) && sgn;
      4: inc = (sh > 0) && (rem >= half);
      default: inc = (rem > half) || ((rem == half) && q[0]);
    endcase
    q = q + inc;
    if (q == (64'd1 << (fw + 1))) begin q = q >> 1; p++; end
    bias = (1 << (ew - 1)) - 1;
    ovf = (p > bias);
    ex = p + bias;
    fr = q & ((64'd1 << fw) - 1);
    if (ovf) begin
      case (mode)
        1: to_inf = 1'b0;
        2: to_inf = !sgn;
        3: to_inf = sgn;
        default: to_inf = 1'b1;
      endcase
      ex = to_inf ? ((64'd1 << ew) - 1) : ((64'd1 << ew) - 2);
      fr = to_inf ? 64'd0 : ((64'd1 << fw) - 1);
    end
    res = (longint'(sgn) << (ew + fw)) | (ex << fw) | fr;
    return {ovf, ovf | (rem != 0), res[31:0]};
  endfunction

  function automatic logic [17:0] h16(input logic [31:0] x, input logic s, input logic [2:0] m);
    logic [33:0] r;
    r = model(x, s, m, 5, 10);
    return {r[33:32], r[15:0]};
  endfunction

  logic [33:0] q32[$];
  logic [17:0] q16[$];
  time         qt[$];
  time         last_stall = 0;
  logic [33:0] e32;
  logic [17:0] e16;
  time         t_acc;

  // Output side: pop on a handshake, otherwise the held word must still match the head.
  always @(negedge clk) begin
    if (!rst) begin
      if (!i_ready) last_stall = $time;
      if (o_valid || o_valid_h) begin
        if (q32.size() == 0) begin
          check("stale_valid", {o_valid, o_valid_h}, 2'b00);
        end else if (o_ready && ce) begin
          e32 = q32.pop_front();
          e16 = q16.pop_front();
          t_acc = qt.pop_front();
          check("res32", {o_overflow, o_inexact, o}, e32);
          check("res16", {o_valid_h, ovf_h, inx_h, oh}, {1'b1, e16});
          if (t_acc > last_stall) check("latency", ($time - t_acc) / 10, 3);
        end else begin
          check("hold32", {o_overflow, o_inexact, o}, q32[0]);
          check("hold16", {ovf_h, inx_h, oh}, q16[0]);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] x, input logic s, input logic [2:0] m,
                      input logic [33:0] x32, input logic [17:0] x16);
    bit acc = 1'b0;
    i = x; op = s; rm = m; i_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (i_ready) begin
        q32.push_back(x32); q16.push_back(x16); qt.push_back($time); acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    check("accept", acc, 1);
  endtask

  task automatic send_m(input logic [31:0] x, input logic s, input logic [2:0] m);
    send(x, s, m, model(x, s, m, 8, 23), h16(x, s, m));
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    for (int k = 0; k < 100 && q32.size() > 0; k++) @(posedge clk);
    #1;
    check("drain", q32.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] x;
    logic [33:0] rmm_exp;
`ifdef I2F_RMM_EN
    rmm_exp = {2'b01, 32'h4B800001};
`else
    rmm_exp = {2'b01, 32'h4B800000};
`endif
    #12;
    check("rst_valid", {o_valid, o_valid_h}, 2'b00);
    check("rst_out", {o_overflow, o_inexact, o}, 34'd0);
    check("rst_ready", i_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    ce = 1'b0; #1;
    check("ce_ready", i_ready, 0);
    ce = 1'b1;
    @(posedge clk); #1;

    // Directed float32 cases (float16 side from the model)
    send(32'h00000001, 1'b1, 3'd0, {2'b00, 32'h3F800000}, h16(32'h00000001, 1'b1, 3'd0));
    send(32'h80000000, 1'b1, 3'd0, {2'b00, 32'hCF000000}, h16(32'h80000000, 1'b1, 3'd0));
    send(32'h00000000, 1'b1, 3'd0, 34'd0, 18'd0);
    send(32'h80000000, 1'b0, 3'd0, {2'b00, 32'h4F000000}, h16(32'h80000000, 1'b0, 3'd0));
    send(32'hFFFFFFFF, 1'b0, 3'd0, {2'b01, 32'h4F800000}, h16(32'hFFFFFFFF, 1'b0, 3'd0));
    send(32'hFFFFFFFF, 1'b0, 3'd1, {2'b01, 32'h4F7FFFFF}, h16(32'hFFFFFFFF, 1'b0, 3'd1));
    send(32'h01000001, 1'b1, 3'd0, {2'b01, 32'h4B800000}, h16(32'h01000001, 1'b1, 3'd0));
    send(32'h01000001, 1'b1, 3'd2, {2'b01, 32'h4B800001}, h16(32'h01000001, 1'b1, 3'd2));
    send(32'h01000001, 1'b1, 3'd4, rmm_exp, h16(32'h01000001, 1'b1, 3'd4));
    send(32'h01000001, 1'b1, 3'd5, {2'b01, 32'h4B800000}, h16(32'h01000001, 1'b1, 3'd5));
    send(32'h01000001, 1'b1, 3'd3, {2'b01, 32'h4B800000}, h16(32'h01000001, 1'b1, 3'd3));
    // Directed float16 overflow cases
    send(32'h00010000, 1'b0, 3'd0, {2'b00, 32'h47800000}, {2'b11, 16'h7C00});
    send(32'h00010000, 1'b0, 3'd1, {2'b00, 32'h47800000}, {2'b11, 16'h7BFF});
    send(32'h00010000, 1'b0, 3'd3, {2'b00, 32'h47800000}, {2'b11, 16'h7BFF});
    send(32'hFFFF0000, 1'b1, 3'd2, {2'b00, 32'hC7800000}, {2'b11, 16'hFBFF});
    send(32'hFFFF0000, 1'b1, 3'd0, {2'b00, 32'hC7800000}, {2'b11, 16'hFC00});
    drain();

    // Random stream with an o_ready stall and a ce stall
    fork
      begin
        for (int n = 0; n < 20; n++) begin
          x = $urandom;
          case ($urandom_range(0, 3))
            0: x = x >> $urandom_range(0, 31);
            1: ;
            2: x = 32'($urandom_range(0, 3));
            default: x = x | 32'h00FFFFFF;
          endcase
          send_m(x, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
      end
      begin
        repeat (6) @(posedge clk); #2 o_ready = 1'b0;
        repeat (5) @(posedge clk); #2 o_ready = 1'b1;
        repeat (4) @(posedge clk); #2 ce = 1'b0;
        repeat (2) @(posedge clk); #2 ce = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three words in flight
    send_m(32'h12345678, 1'b0, 3'd0);
    send_m(32'hDEADBEEF, 1'b1, 3'd1);
    send_m(32'h00000007, 1'b0, 3'd2);
    check("pre_rst_valid", o_valid, 1);
    rst = 1'b1; #1;
    check("arst_valid", {o_valid, o_valid_h}, 2'b00);
    check("arst_out", {o_overflow, o_inexact, o}, 34'd0);
    check("arst_out16", {ovf_h, inx_h, oh}, 18'd0);
    q32.delete(); q16.delete(); qt.delete();
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("post_rst_ready", i_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_rst_idle", o_valid, 0);
    end
    @(posedge clk); #1;
    send_m(32'hFFFFFF85, 1'b1, 3'd0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
